// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Brief    : Multi-port register file (NUM_READ reads, 2 writes) with a
//            per-entry pending scoreboard; r0 hardwired to zero.
//            Optional write-through forwarding: define REG_FILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
    parameter int LEN_REG_FILE_ADDR = 5,
    parameter int SIZE_REG_FILE     = 32,
    parameter int LEN_WORD          = 32,
    parameter int NUM_READ          = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  write_en_1,
    input  logic [LEN_REG_FILE_ADDR-1:0]          dst_1,
    input  logic [LEN_WORD-1:0]                   write_data_1,
    input  logic                                  write_en_2,
    input  logic [LEN_REG_FILE_ADDR-1:0]          dst_2,
    input  logic [LEN_WORD-1:0]                   write_data_2,
    input  logic                                  reserve_en,
    input  logic [LEN_REG_FILE_ADDR-1:0]          reserve_dst,
    input  logic [NUM_READ*LEN_REG_FILE_ADDR-1:0] src,
    output logic [NUM_READ*LEN_WORD-1:0]          read_data,
    output logic [NUM_READ-1:0]                   read_pending
);

    localparam logic [31:0] c_SIZE_U = SIZE_REG_FILE;

    logic [LEN_WORD-1:0]      mem_q [SIZE_REG_FILE];
    logic [LEN_WORD-1:0]      mem_d [SIZE_REG_FILE];
    logic [SIZE_REG_FILE-1:0] pending_q;
    logic [SIZE_REG_FILE-1:0] pending_d;

    // Register 0 and addresses beyond the array are never stored or reserved.
    function automatic logic addr_ok(input logic [LEN_REG_FILE_ADDR-1:0] a);
        return (a != '0) && (32'(a) < c_SIZE_U);
    endfunction

    logic w_wr1_ok;
    logic w_wr2_ok;
    logic w_rsv_ok;

    assign w_wr1_ok = write_en_1 && addr_ok(dst_1);
    assign w_wr2_ok = write_en_2 && addr_ok(dst_2);
    assign w_rsv_ok = reserve_en && addr_ok(reserve_dst);

    // Port 2 is applied after port 1 so it wins on a shared address; the
    // reservation is applied last so a newer producer keeps the entry pending.
    always_comb begin
        mem_d     = mem_q;
        pending_d = pending_q;
        if (w_wr1_ok) begin
            mem_d[dst_1]     = write_data_1;
            pending_d[dst_1] = 1'b0;
        end
        if (w_wr2_ok) begin
            mem_d[dst_2]     = write_data_2;
            pending_d[dst_2] = 1'b0;
        end
        if (w_rsv_ok) begin
            pending_d[reserve_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SIZE_REG_FILE; i++) begin
                mem_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            mem_q     <= mem_d;
            pending_q <= pending_d;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [LEN_REG_FILE_ADDR-1:0] w_src;
        logic                         w_ok;
        logic [LEN_WORD-1:0]          w_stored;
        logic                         w_stored_pend;

        assign w_src         = src[k*LEN_REG_FILE_ADDR +: LEN_REG_FILE_ADDR];
        assign w_ok          = addr_ok(w_src);
        assign w_stored      = w_ok ? mem_q[w_src] : '0;
        assign w_stored_pend = w_ok ? pending_q[w_src] : 1'b0;

`ifdef REG_FILE_BYPASS_EN
        // A same-cycle writeback resolves the hazard before it is stored.
        always_comb begin
            read_data[k*LEN_WORD +: LEN_WORD] = w_stored;
            read_pending[k]                   = w_stored_pend;
            if (w_wr2_ok && (dst_2 == w_src)) begin
                read_data[k*LEN_WORD +: LEN_WORD] = write_data_2;
                read_pending[k]                   = 1'b0;
            end else if (w_wr1_ok && (dst_1 == w_src)) begin
                read_data[k*LEN_WORD +: LEN_WORD] = write_data_1;
                read_pending[k]                   = 1'b0;
            end
        end
`else
        assign read_data[k*LEN_WORD +: LEN_WORD] = w_stored;
        assign read_pending[k]                   = w_stored_pend;
`endif
    end

endmodule
`default_nettype wire

// File: doc/reg_file_mp.md
# reg_file_mp

Multi-port register file with hazard scoreboard for the MIPS pipeline decode/writeback stages. It generalises the single-write, dual-read register file to `NUM_READ` read ports and two write ports. Each entry carries a pending bit, set when an in-flight instruction reserves its destination and cleared when that result is written back. Register 0 is hardwired to zero. Optional write-through forwarding removes the writeback-to-decode bubble.

## Interface
- `LEN_REG_FILE_ADDR`, default 5: address width.
- `SIZE_REG_FILE`, default 32: number of entries, ≤ 2^`LEN_REG_FILE_ADDR`.
- `LEN_WORD`, default 32: data width.
- `NUM_READ`, default 2: number of read ports, ≥ 1.

Ports. The clock is `clk`; the reset is `reset`, synchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous active-high reset.
- `write_en_1`  in  1  write port 1 enable.
- `dst_1`  in  `LEN_REG_FILE_ADDR`  write port 1 address.
- `write_data_1`  in  `LEN_WORD`  write port 1 data.
- `write_en_2`  in  1  write port 2 enable (higher priority).
- `dst_2`  in  `LEN_REG_FILE_ADDR`  write port 2 address.
- `write_data_2`  in  `LEN_WORD`  write port 2 data.
- `reserve_en`  in  1  mark `reserve_dst` pending.
- `reserve_dst`  in  `LEN_REG_FILE_ADDR`  register to reserve.
- `src`  in  `NUM_READ*LEN_REG_FILE_ADDR`  packed read addresses; port k is at bits [k*LEN_REG_FILE_ADDR +: LEN_REG_FILE_ADDR].
- `read_data`  out  `NUM_READ*LEN_WORD`  packed read data, same packing.
- `read_pending`  out  `NUM_READ`  bit k is 1 when port k's data is not yet valid.

## Operation
- Storage: `SIZE_REG_FILE` × `LEN_WORD` data array plus a `SIZE_REG_FILE`-bit pending vector.
- Reset:
  - All data entries clear to 0, including every entry, not just the first `LEN_WORD`.
  - All pending bits clear.
  - Reset overrides writes and reservations in the same cycle.
- Writes:
  - Port n writes `write_data_n` to `dst_n` when `write_en_n`=1.
  - If both ports target the same address, port 2's data is stored.
  - A write clears the pending bit of its destination.
- Reservations:
  - `reserve_en`=1 sets `pending[reserve_dst]`.
  - If a write and a reservation hit the same register in the same cycle, the write data is stored and the pending bit ends up set, because the newer producer wins.
- Register 0 and out-of-range addresses (≥ `SIZE_REG_FILE`):
  - Writes and reservations to them are ignored.
  - Reads from them return 0 with `read_pending`=0.
- Reads are combinational from `src`:
  - `read_data` slice k is the stored entry for `src` slice k.
  - `read_pending[k]` is the stored pending bit for that entry.
- No state machine beyond the array and pending vector. All sequential state is the storage updated above.

## Timing
- Write latency: data is stored at the edge where `write_en_n`=1.
  - Without forwarding, it is visible on `read_data` in the following cycle.
- Pending set latency: `read_pending` rises in the cycle after the `reserve_en` edge.
- Pending clear latency: `read_pending` falls in the cycle after the writeback edge, unless forwarded (see Configuration).
- Reset: from the first cycle after the reset edge, `read_data`=0 and `read_pending`=0 on all ports.
  - Reset asserted mid-stream discards any same-cycle write or reservation.
- Read paths have no registers; a read-port address change is reflected in the same cycle.

## Configuration
- Macro `REG_FILE_BYPASS_EN`.
- Defined (forwarding on): when a read port's address equals an enabled write port's nonzero, in-range address in the same cycle:
  - `read_data` returns that write port's data, combinationally. Port 2 wins if both ports match.
  - `read_pending` for that port is 0, even if the entry is marked pending.
  - A same-cycle reservation does not affect the current read; it takes effect next cycle.
- Undefined (forwarding off): reads always return stored contents. A same-cycle write is invisible until the next cycle.

## Test plan
- Reset clears all entries:
  - Stimulus: write 0xDEADBEEF to all 31 nonzero registers, then assert `reset` for 1 cycle.
  - Required: every register, including r31, reads 0 with pending 0.
- Dual-write conflict:
  - Stimulus: port 1 writes r5=0x11111111 and port 2 writes r5=0x22222222 in the same cycle.
  - Required: r5 reads 0x22222222 next cycle.
- Register 0:
  - Stimulus: write r0=0xFFFFFFFF and reserve r0.
  - Required: r0 reads 0 with pending 0 on all `NUM_READ` ports.
- Scoreboard:
  - Stimulus: reserve r7, wait 3 cycles, then write r7=0x1234.
  - Required: pending=1 for 3 cycles; pending=0 and data 0x1234 after the write edge. The forwarded build shows this in the write cycle itself.
- Reserve and write collide:
  - Stimulus: in one cycle, write r9=0xABCD and reserve r9.
  - Required: next cycle r9 reads 0xABCD with pending=1.
- Forwarding (macro defined):
  - Stimulus: `src` slice 0 = r3 while port 1 writes r3=0x55.
  - Required: read_data slice 0 = 0x55 in the same cycle. The undefined build shows the old value until the next cycle.
